hex_display_scan: RTL and testbench
===================================

# hex_display_scan

Downstream display stage for the single-cycle datapath on the Basys 2 board. It consumes the three 16-bit debug taps the datapath exports (Rs, Rt and register-file write data, each the low halfword) plus the low halfword of the PC. It shows one of them on the 4-digit multiplexed seven-segment display. A debounced pushbutton cycles the selection, and the decimal points indicate which source is shown.

## Interface
Parameters:
- REFRESH_BITS, 16: width of the free-running scan counter; each digit is lit for 2^(REFRESH_BITS-2) cycles.
- DEBOUNCE_BITS, 16: the button must be stable for 2^DEBOUNCE_BITS consecutive cycles before its debounced level changes.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- rs_lsh  in  16  Rs low halfword from the datapath.
- rt_lsh  in  16  Rt / write-data low halfword from the datapath.
- rfin_lsh  in  16  register-file write data low halfword.
- pc_lsh  in  16  PC[15:0].
- sel_btn  in  1  raw pushbutton, asynchronous, active-high.
- an  out  4  digit anodes, active-low; an[3] is the leftmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- sel  out  2  current source: 0 = RS, 1 = RT, 2 = RFIN, 3 = PC.

## Operation
- **Synchronizer:** sel_btn passes through two flops before any use.
- **Debouncer:**
  - The counter resets to 0 whenever the synchronized input equals the debounced level; otherwise it increments.
  - When the counter reaches all-ones, the debounced level toggles and the counter clears.
  - The debounced level resets to 0.
- **Select FSM:**
  - States are RS, RT, RFIN and PC; reset state is RS.
  - A debounced rising edge advances RS→RT→RFIN→PC→RS, wrapping from PC to RS.
  - A debounced falling edge, or a held button, does nothing.
  - `sel` is the state encoding.
- **Source mux:** selects the halfword to display according to `sel`.
  - Inputs are sampled live; there is no snapshot.
  - A value change is visible at the next digit refresh.
- **Scan counter:**
  - REFRESH_BITS wide, free-running, wraps at all-ones to 0.
  - digit = counter[REFRESH_BITS-1:REFRESH_BITS-2].
  - digit 0 drives an[0] with nibble [3:0]; digit 3 drives an[3] with nibble [15:12].
- **Hex decode** (active-low):
  - 0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110.
  - The full 0–F table is the standard Basys encoding.
- **Decimal point:** dp = 0 (lit) only while the digit index equals `sel`.
  - RS lights the DP of digit 0, PC lights the DP of digit 3.
- **Registered outputs:** an, seg and dp are all registered; there are no combinational paths from inputs to these pins.

## Timing
- **Reset values** (asserted asynchronously, takes effect immediately):
  - an = 1111, seg = 1111111, dp = 1, sel = 0.
  - Scan counter = 0, debounce counter = 0, debounced level = 0, synchronizer flops = 0.
- **Output latency:** an/seg/dp reflect the digit index and source value one clk after the counter value that selects them.
  - The first lit digit after reset release is an = 1110, one cycle after release.
- **Source-change latency:** a change on the selected input reaches seg within one cycle, when that digit is active.
- **Button latency:** a clean press reaches `sel` in 2 (sync) + 2^DEBOUNCE_BITS + 1 cycles; `sel` changes on a single edge.
- **Glitch rejection:** glitches shorter than 2^DEBOUNCE_BITS cycles never change the debounced level.
- **Sel change mid-digit:** new data and DP appear on the next cycle, with no blanking.
- **Reset mid-operation:** reset asserted during debounce or mid-scan returns everything to the reset values; a press in progress is discarded.

## Structure
- Shared package `display_pkg` holds:
  - The select-state encoding (SEL_RS/RT/RFIN/PC).
  - The 16-entry hex-to-segment constant table.
  - SEG_BLANK = 7'b1111111.
- One sub-module, `hex7seg`: combinational 4-bit nibble to active-low 7-bit segment decode, instantiated once after the nibble mux.
- The debouncer and the FSM stay inline.

## Test plan
All tests use REFRESH_BITS = 4 and DEBOUNCE_BITS = 3.
- **Reset:** assert reset mid-scan → an = 1111, seg = 1111111, dp = 1, sel = 0 immediately (asynchronously); after release, an = 1110 within 1 cycle.
- **Scan:** rs_lsh = 16'h8A1F, sel = RS → an/seg sequence 1110/0001110 (F), 1101/1111001 (1), 1011/0001000 (A), 0111/0000000 (8), 4 cycles each, repeating; dp = 0 only during an = 1110.
- **Select wrap:** four clean 20-cycle presses → sel 1, 2, 3, 0; with pc_lsh = 16'h0040, sel = 3 shows digit 1 as "4" and dp lit on an = 0111.
- **Debounce:** 5-cycle pulse on sel_btn → sel unchanged; held high 40 cycles → exactly one advance; release bounce of alternating 1-cycle toggles → no advance.
- **Live update:** while sel = RT, change rt_lsh from 16'h0000 to 16'h000F while digit 0 is active → seg = 0001110 on the next cycle.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - select encoding and seven-segment table for the display scanner
package display_pkg;

  typedef enum logic [1:0] {
    SEL_RS   = 2'd0,
    SEL_RT   = 2'd1,
    SEL_RFIN = 2'd2,
    SEL_PC   = 2'd3
  } sel_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry 0 sits in the least significant slot.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - nibble to active-low seven-segment decode
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG_TABLE[nibble];

endmodule

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - four-digit hex scanner with debounced source select
module hex_display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_BITS  = 16,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rs_lsh,
  input  logic [15:0] rt_lsh,
  input  logic [15:0] rfin_lsh,
  input  logic [15:0] pc_lsh,
  input  logic        sel_btn,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  sel
);

  logic                     sync1_q, sync2_q;
  logic [DEBOUNCE_BITS-1:0] db_cnt_q, db_cnt_d;
  logic                     level_q, level_d;
  logic                     level_prev_q;
  sel_e                     sel_q;
  logic [REFRESH_BITS-1:0]  scan_q, scan_d;
  logic [1:0]               digit;
  logic [15:0]              src;
  logic [3:0]               nibble;
  logic [6:0]               seg_dec;
  logic [3:0]               an_q, an_d;
  logic [6:0]               seg_q;
  logic                     dp_q, dp_d;

  // Level only flips after the synchronized input has disagreed for a full counter span.
  always_comb begin
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (&db_cnt_q) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DEBOUNCE_BITS'(1);
    end
  end

  assign scan_d = scan_q + REFRESH_BITS'(1);
  assign digit  = scan_q[REFRESH_BITS-1 -: 2];

  always_comb begin
    case (sel_q)
      SEL_RS:   src = rs_lsh;
      SEL_RT:   src = rt_lsh;
      SEL_RFIN: src = rfin_lsh;
      default:  src = pc_lsh;
    endcase
    case (digit)
      2'd0:    nibble = src[3:0];
      2'd1:    nibble = src[7:4];
      2'd2:    nibble = src[11:8];
      default: nibble = src[15:12];
    endcase
    an_d = ~(4'b0001 << digit);
    dp_d = (digit != sel_q);
  end

  hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      scan_q   <= '0;
      an_q     <= 4'b1111;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      sync1_q  <= sel_btn;
      sync2_q  <= sync1_q;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      scan_q   <= scan_d;
      an_q     <= an_d;
      seg_q    <= seg_dec;
      dp_q     <= dp_d;
    end
  end

  // Advance only on a debounced rising edge; holds and releases are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q        <= SEL_RS;
      level_prev_q <= 1'b0;
    end else begin
      level_prev_q <= level_q;
      if (level_q && !level_prev_q) begin
        case (sel_q)
          SEL_RS:   sel_q <= SEL_RT;
          SEL_RT:   sel_q <= SEL_RFIN;
          SEL_RFIN: sel_q <= SEL_PC;
          default:  sel_q <= SEL_RS;
        endcase
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
  assign sel = sel_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// tb/tb_hex_display_scan.sv - directed self-checking bench for hex_display_scan
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rs_lsh, rt_lsh, rfin_lsh, pc_lsh;
  logic        sel_btn;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  sel;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hex_display_scan #(
    .REFRESH_BITS  (4),
    .DEBOUNCE_BITS (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rs_lsh   (rs_lsh),
    .rt_lsh   (rt_lsh),
    .rfin_lsh (rfin_lsh),
    .pc_lsh   (pc_lsh),
    .sel_btn  (sel_btn),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .sel      (sel)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(negedge clk);
      if (an === v) hit = 1'b1;
    end
    check("wait_an", 32'(hit), 32'd1);
  endtask

  task automatic press(input int high, input int low);
    sel_btn = 1'b1;
    cycles(high);
    sel_btn = 1'b0;
    cycles(low);
  endtask

  logic [6:0] exp_seg [4];
  logic [3:0] exp_an;
  int         d;
  int         lat;

  initial begin
    exp_seg  = '{7'b0001110, 7'b1111001, 7'b0001000, 7'b0000000};
    rs_lsh   = 16'h8A1F;
    rt_lsh   = 16'h0000;
    rfin_lsh = 16'h1234;
    pc_lsh   = 16'h0040;
    sel_btn  = 1'b0;

    #3 reset = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_sel", 32'(sel), 32'd0);

    @(negedge clk);
    reset = 1'b1;

    // Digit k-1 of the scan counter shows up after the k-th edge.
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      d      = ((k - 1) / 4) % 4;
      exp_an = ~(4'b0001 << d);
      check("scan_an", 32'(an), 32'(exp_an));
      check("scan_seg", 32'(seg), 32'(exp_seg[d]));
      check("scan_dp", 32'(dp), (d == 0) ? 32'd0 : 32'd1);
    end

    sel_btn = 1'b1;
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      @(negedge clk);
      if (sel !== 2'd0) lat = i;
    end
    check("press_latency", 32'(lat), 32'd11);
    check("sel_after_1", 32'(sel), 32'd1);
    cycles(9);
    sel_btn = 1'b0;
    cycles(20);
    press(20, 20);
    check("sel_after_2", 32'(sel), 32'd2);
    press(20, 20);
    check("sel_after_3", 32'(sel), 32'd3);

    wait_an(4'b1101);
    check("pc_digit1_seg", 32'(seg), 32'h19);
    check("pc_digit1_dp", 32'(dp), 32'd1);
    wait_an(4'b0111);
    check("pc_digit3_dp", 32'(dp), 32'd0);
    check("pc_digit3_seg", 32'(seg), 32'h40);

    press(20, 20);
    check("sel_wrap", 32'(sel), 32'd0);

    press(5, 20);
    check("glitch_reject", 32'(sel), 32'd0);

    sel_btn = 1'b1;
    cycles(40);
    check("held_one_adv", 32'(sel), 32'd1);
    repeat (5) begin
      sel_btn = 1'b0;
      cycles(1);
      sel_btn = 1'b1;
      cycles(1);
    end
    sel_btn = 1'b0;
    cycles(20);
    check("bounce_no_adv", 32'(sel), 32'd1);

    wait_an(4'b0111);
    wait_an(4'b1110);
    check("live_before", 32'(seg), 32'h40);
    rt_lsh = 16'h000F;
    @(negedge clk);
    check("live_after_seg", 32'(seg), 32'h0E);
    check("live_after_an", 32'(an), 32'hE);

    sel_btn = 1'b1;
    cycles(6);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_dp", 32'(dp), 32'd1);
    check("mid_rst_sel", 32'(sel), 32'd0);
    sel_btn = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rel_an", 32'(an), 32'hE);
    cycles(20);
    check("press_discarded", 32'(sel), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
